// File: rtl/tx_gearbox_66b64.sv
// tx_gearbox_66b64 -- packs 66-bit sync-header blocks into a continuous 64-bit TX word stream.
// Optional payload scrambler (1+x^39+x^58) enabled by defining TX_SCRAMBLE_EN. Rev 1.0
`default_nettype none

module tx_gearbox_66b64 #(
  parameter int SEQ_LEN   = 33,
  parameter bit HDR_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        s_vld,
  input  logic [1:0]  s_hdr,
  input  logic [63:0] s_data,
  output logic        s_rdy,
  output logic [63:0] tx_data,
  output logic        tx_vld,
  output logic        hdr_err,
  output logic [5:0]  seq_cnt
);

  localparam logic [5:0] LAST_POS = 6'(SEQ_LEN - 1);

  logic [5:0]   seq_q, seq_d;
  logic [63:0]  res_q, res_d;
  logic [63:0]  tx_q, tx_d;
  logic         vld_q, vld_d;
  logic         err_q, err_d;

  logic         w_acc;
  logic         w_pause;
  logic         w_bad;
  logic [63:0]  w_pay;
  logic [65:0]  w_blk;
  logic [127:0] w_shl;

  assign w_pause = en && (seq_q == LAST_POS);
  assign w_acc   = en && s_vld && (seq_q != LAST_POS);
  assign s_rdy   = !rst && (seq_q != LAST_POS);

`ifdef TX_SCRAMBLE_EN
  logic [57:0] scr_q;
  logic [57:0] scr_d;

  // Extended vector holds 58 history bits below the 64 new scrambled bits.
  function automatic logic [63:0] scramble(input logic [57:0] st, input logic [63:0] x);
    logic [121:0] e;
    e = {64'b0, st};
    for (int i = 0; i < 64; i++) begin
      e[58+i] = x[i] ^ e[19+i] ^ e[i];
    end
    return e[121:58];
  endfunction

  assign w_pay = scramble(scr_q, s_data);
  assign scr_d = w_acc ? w_pay[63:6] : scr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scr_q <= '1;
    end else begin
      scr_q <= scr_d;
    end
  end
`else
  assign w_pay = s_data;
`endif

  assign w_blk = {w_pay, s_hdr};
  // Bits above 63 of the shifted block are exactly the new residual.
  assign w_shl = {62'b0, w_blk} << {seq_q, 1'b0};

  generate
    if (HDR_CHECK) begin : g_hdr_chk
      assign w_bad = (s_hdr[1] == s_hdr[0]);
    end else begin : g_hdr_nochk
      assign w_bad = 1'b0;
    end
  endgenerate

  always_comb begin
    seq_d = seq_q;
    res_d = res_q;
    tx_d  = tx_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    if (w_pause) begin
      tx_d  = res_q;
      res_d = '0;
      seq_d = '0;
      vld_d = 1'b1;
    end else if (w_acc) begin
      tx_d  = w_shl[63:0] | res_q;
      res_d = w_shl[127:64];
      seq_d = seq_q + 6'd1;
      vld_d = 1'b1;
      err_d = w_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
      res_q <= '0;
      tx_q  <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      seq_q <= seq_d;
      res_q <= res_d;
      tx_q  <= tx_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  assign tx_data = tx_q;
  assign tx_vld  = vld_q;
  assign hdr_err = err_q;
  assign seq_cnt = seq_q;

endmodule

`default_nettype wire

// File: doc/tx_gearbox_66b64.md
Name: tx_gearbox_66b64

Overview:
- Transmit-side counterpart of the 64b/66b receive block lock.
- Accepts one 66-bit block per beat: a 2-bit sync header plus a 64-bit payload.
- Packs blocks into a continuous 64-bit word stream for the transceiver TX datapath, header first.
- Every 32 accepted blocks produce 33 output words, so the block requests one upstream pause per 33-word sequence.

Parameters:
- SEQ_LEN, 33, output words per gearbox sequence (fixed by 66/64 ratio; only 33 is supported).
- HDR_CHECK, 1, when 1 drives hdr_err; when 0, hdr_err is tied to 0.

Ports:
- clk       input   1   transmit clock; all logic on rising edge.
- rst       input   1   synchronous, active-high reset.
- en        input   1   gearbox advance enable (transceiver TX clock-enable); nothing advances while 0.
- s_vld     input   1   upstream block valid.
- s_hdr     input   2   sync header (2'b01 data, 2'b10 control); transmitted first, bit 0 first.
- s_data    input   64  block payload; bit 0 transmitted first after the header.
- s_rdy     output  1   block accepted when s_vld && s_rdy && en.
- tx_data   output  64  packed output word; bit 0 transmitted first.
- tx_vld    output  1   tx_data valid this cycle.
- hdr_err   output  1   one-cycle pulse: an accepted block carried header 2'b00 or 2'b11.
- seq_cnt   output  6   current sequence position 0..32, for debug and verification.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. All state clears on the clock edge where rst=1.
- Reset values: tx_data=0, tx_vld=0, hdr_err=0, seq_cnt=0, residual=0, and s_rdy=0 while rst=1.
- Ready: s_rdy = !rst && (seq_cnt != 32). It is combinational from registered state and does not depend on s_vld.
- Block vector: B = {s_data, s_hdr}, 66 bits, with the header in B[1:0].
- Residual register R holds 2*seq_cnt valid bits in its LSBs.
- Accept beat, seq_cnt = k in 0..31 and s_vld && en:
  - tx_data <= low 64 bits of ({B, R[2k-1:0]}).
  - R <= B >> (64-2k).
  - seq_cnt <= k+1.
  - tx_vld <= 1.
- Pause beat, seq_cnt = 32 and en:
  - tx_data <= R[63:0], all 64 residual bits.
  - R <= 0; seq_cnt <= 0; tx_vld <= 1.
  - No block is accepted.
- Stall: if en=0, or if seq_cnt<32 and s_vld=0, then tx_vld <= 0 and seq_cnt, R and the scrambler state hold. Keeping s_vld continuous is the source's responsibility.
- Latency: 1 cycle from accept edge to tx_data/tx_vld.
- hdr_err: registered, aligned with the tx_data word that carries the header. The bad header is transmitted unmodified.
- Wrap: seq_cnt runs 31 -> 32 on the 32nd accept, then 32 -> 0 on the pause beat.
- Reset mid-sequence: the partial residual is discarded. The first block after reset starts at seq_cnt=0 with the header at tx_data[1:0].

Optional Feature:
- Macro: TX_SCRAMBLE_EN.
- When defined: the payload only (never the header) is scrambled with the self-synchronous polynomial 1+x^39+x^58 before packing.
  - Bit order is LSB first: y[i] = x[i] ^ y[i-39] ^ y[i-58].
  - State is the 58 most recent scrambled bits; it resets to all ones and updates only on accept beats.
  - Combinational with the accept; latency is unchanged.
- When not defined: the payload passes unmodified and there is no scrambler state.

Test Plan:
- Reset, then s_hdr=2'b01, s_data=64'h0 at seq 0 -> tx_data=64'h0000_0000_0000_0001, tx_vld=1 one cycle later; R holds 2'b00.
- 40 back-to-back valid blocks, en=1 -> exactly 32 accepts; s_rdy=0 only at seq_cnt=32; tx_vld high for all 33 words; accepts resume at seq_cnt=0.
- Reconstruct the serial stream from the 33 words -> it equals the 32 input blocks concatenated, header first; a 2'b10 header is seen at bit offset 66*n.
- s_hdr=2'b11 on the block at seq 7 -> hdr_err=1 for one cycle, aligned with its word; tx_data still carries 2'b11.
- s_vld=0 for 3 cycles at seq 5, then en=0 for 2 cycles -> tx_vld=0 for 5 cycles; seq_cnt holds at 5; output resumes with no lost or duplicated bits.
- rst=1 at seq 10 -> next block lands at seq 0 with header at tx_data[1:0]. With TX_SCRAMBLE_EN, hdr=01 and data=0 -> tx_data=64'h0FFF_FE00_0000_0001.
